// File: rtl/mult_pkg.sv
// mult_pkg: shared loader/multiplier definitions (FSM states and default widths).
package mult_pkg;
    localparam int OP_W_DEF   = 32;
    localparam int BYTE_W_DEF = 8;
    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, PRESENT} state_e;
endpackage

// File: rtl/byte_shift_assembler.sv
// byte_shift_assembler: writes serial bytes LSB-first into an operand register.
module byte_shift_assembler #(
    parameter int OP_W   = 32,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_i,
    input  logic              start_i,
    input  logic              clr_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [OP_W-1:0]   data_o,
    output logic              last_o
);
    localparam int NB = OP_W / BYTE_W;
    localparam int IW = NB > 1 ? $clog2(NB) : 1;
    logic [IW-1:0]   idx_q, idx_d, lane;
    logic [OP_W-1:0] data_q, data_d;
    always_comb begin
        lane   = start_i ? '0 : idx_q;
        idx_d  = clr_i ? '0 : idx_q;
        data_d = data_q;
        if (wr_i || start_i) begin
            data_d[lane*BYTE_W +: BYTE_W] = byte_i;
            idx_d = (lane == IW'(NB-1)) ? '0 : lane + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q  <= '0;
            data_q <= '0;
        end else begin
            idx_q  <= idx_d;
            data_q <= data_d;
        end
    end
    assign data_o = data_q;
    assign last_o = idx_q == IW'(NB-1);
endmodule

// File: rtl/mult_operand_loader.sv
// mult_operand_loader: assembles byte-serial A/B operand pairs for the multiplier,
// with inter-byte timeout and start-of-frame resynchronisation.
module mult_operand_loader
    import mult_pkg::*;
#(
    parameter int OP_W    = OP_W_DEF,
    parameter int BYTE_W  = BYTE_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_sof,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OP_W-1:0]   op_a,
    output logic [OP_W-1:0]   op_b,
    output logic              op_valid,
    input  logic              op_ready,
    output logic              err_pulse
);
    localparam int NB = OP_W / BYTE_W;
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        in_ready_q, op_valid_q, err_q, err_d;
    logic        acc, loading, expired;
    logic        a_wr, a_start, a_clr, a_last, b_wr, b_clr, b_last;
    always_comb begin
        acc     = in_valid & in_ready_q;
        loading = state_q == LOAD_A || state_q == LOAD_B;
        expired = loading && !acc && cnt_q == 16'(TIMEOUT-1);
        cnt_d   = (loading && !acc && !expired) ? cnt_q + 16'd1 : '0;
        state_d = state_q;
        err_d   = 1'b0;
        a_wr    = 1'b0;
        a_start = 1'b0;
        a_clr   = 1'b0;
        b_wr    = 1'b0;
        b_clr   = 1'b0;
        if (state_q == PRESENT) begin
            state_d = (op_valid_q && op_ready) ? IDLE : PRESENT;
        end else if (acc && in_sof) begin
            // SOF always (re)starts a frame; it is an error only if one was in progress
            err_d   = loading;
            a_start = 1'b1;
            b_clr   = 1'b1;
            state_d = (NB == 1) ? LOAD_B : LOAD_A;
        end else if (acc && state_q == LOAD_A) begin
            a_wr    = 1'b1;
            state_d = a_last ? LOAD_B : LOAD_A;
        end else if (acc && state_q == LOAD_B) begin
            b_wr    = 1'b1;
            state_d = b_last ? PRESENT : LOAD_B;
        end else if (expired) begin
            err_d   = 1'b1;
            a_clr   = 1'b1;
            b_clr   = 1'b1;
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            op_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_ready_q <= state_d != PRESENT;
            op_valid_q <= state_d == PRESENT;
            err_q      <= err_d;
        end
    end
    byte_shift_assembler #(.OP_W(OP_W), .BYTE_W(BYTE_W)) u_asm_a (
        .clk(clk), .rst(rst), .wr_i(a_wr), .start_i(a_start), .clr_i(a_clr),
        .byte_i(in_data), .data_o(op_a), .last_o(a_last)
    );
    byte_shift_assembler #(.OP_W(OP_W), .BYTE_W(BYTE_W)) u_asm_b (
        .clk(clk), .rst(rst), .wr_i(b_wr), .start_i(1'b0), .clr_i(b_clr),
        .byte_i(in_data), .data_o(op_b), .last_o(b_last)
    );
    assign in_ready  = in_ready_q;
    assign op_valid  = op_valid_q;
    assign err_pulse = err_q;
endmodule

// File: tb/tb_mult_operand_loader.sv
// tb_mult_operand_loader: directed and random frames checked against a frame-level model.
module tb_mult_operand_loader;
    localparam int NB = 4;
    localparam int TO = 255;
    logic        clk = 1'b0, rst = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_sof = 1'b0, in_valid = 1'b0, op_ready = 1'b0;
    logic        in_ready, op_valid, err_pulse;
    logic [31:0] op_a, op_b;
    int          checks = 0, failures = 0;
    int          n_err = 0, n_vrise = 0;
    bit          rnd = 1'b0, prev_valid = 1'b0;

    mult_operand_loader #(.OP_W(32), .BYTE_W(8), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sof(in_sof), .in_valid(in_valid),
        .in_ready(in_ready), .op_a(op_a), .op_b(op_b), .op_valid(op_valid),
        .op_ready(op_ready), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: counts bytes of the current frame and idle cycles.
    logic [31:0] m_a = '0, m_b = '0;
    bit          m_ready = 0, m_present = 0, m_err = 0, m_inframe = 0;
    int          m_pos = 0, m_idle = 0;

    task automatic m_put(input logic [7:0] d);
        if (m_pos < NB) m_a[m_pos*8 +: 8] = d;
        else m_b[(m_pos-NB)*8 +: 8] = d;
        m_pos++;
        if (m_pos == 2*NB) begin
            m_present = 1;
            m_inframe = 0;
        end
    endtask

    task automatic m_step();
        bit acc;
        acc   = in_valid && m_ready;
        m_err = 0;
        if (m_present) begin
            if (op_ready) m_present = 0;
        end else if (acc && in_sof) begin
            m_err     = m_inframe;
            m_inframe = 1;
            m_pos     = 0;
            m_idle    = 0;
            m_put(in_data);
        end else if (m_inframe) begin
            if (acc) begin
                m_idle = 0;
                m_put(in_data);
            end else begin
                m_idle++;
                if (m_idle == TO) begin
                    m_err     = 1;
                    m_inframe = 0;
                    m_idle    = 0;
                end
            end
        end
        m_ready = !m_present;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_a = '0; m_b = '0; m_ready = 0; m_present = 0; m_err = 0;
            m_inframe = 0; m_pos = 0; m_idle = 0;
        end else m_step();
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("in_ready", 32'(in_ready), 32'(m_ready));
            chk("op_valid", 32'(op_valid), 32'(m_present));
            chk("err_pulse", 32'(err_pulse), 32'(m_err));
            chk("op_a", op_a, m_a);
            chk("op_b", op_b, m_b);
            n_err += int'(err_pulse);
            if (op_valid && !prev_valid) n_vrise++;
            prev_valid = op_valid;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rnd) op_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [7:0] d, input bit sof);
        int w;
        bit rdy;
        w = 0;
        in_data = d; in_sof = sof; in_valid = 1'b1;
        do begin
            rdy = in_ready;
            @(negedge clk);
            w++;
        end while (!rdy && w < 200);
        in_valid = 1'b0; in_sof = 1'b0;
        if (!rdy) begin
            checks++; failures++;
            $display("FAIL send_wait actual=no_accept expected=accept_within_200 t=%0t", $time);
        end
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] f;
        f = {b, a};
        for (int i = 0; i < 2*NB; i++) send(f[i*8 +: 8], i == 0);
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int e0, v0;
        gap(2);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_op_valid", 32'(op_valid), 32'd0);
        chk("rst_err", 32'(err_pulse), 32'd0);
        chk("rst_op_a", op_a, 32'd0);
        rst = 1'b1;
        gap(1);
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        // 1: basic frame, downstream ready
        op_ready = 1'b1;
        send_frame(32'h12345678, 32'h87654321);
        chk("t1_valid", 32'(op_valid), 32'd1);
        chk("t1_op_a", op_a, 32'h12345678);
        chk("t1_op_b", op_b, 32'h87654321);
        chk("t1_in_ready", 32'(in_ready), 32'd0);
        gap(1);
        chk("t1_valid_drop", 32'(op_valid), 32'd0);
        chk("t1_ready_back", 32'(in_ready), 32'd1);
        // 2: downstream stall
        op_ready = 1'b0;
        send_frame(32'h12345678, 32'h87654321);
        gap(10);
        chk("t2_held", 32'(op_valid), 32'd1);
        chk("t2_in_ready", 32'(in_ready), 32'd0);
        chk("t2_op_b", op_b, 32'h87654321);
        op_ready = 1'b1;
        gap(1);
        chk("t2_released", 32'(op_valid), 32'd0);
        chk("t2_ready_back", 32'(in_ready), 32'd1);
        // 3: timeout after 3 A bytes
        send(8'h01, 1'b1); send(8'h02, 1'b0); send(8'h03, 1'b0);
        gap(TO-1);
        chk("t3_no_err_early", 32'(err_pulse), 32'd0);
        gap(1);
        chk("t3_err", 32'(err_pulse), 32'd1);
        gap(1);
        chk("t3_err_pulse_len", 32'(err_pulse), 32'd0);
        send_frame(32'd2, 32'd3);
        chk("t3_op_a", op_a, 32'd2);
        chk("t3_op_b", op_b, 32'd3);
        gap(1);
        // 4: early SOF after 5 bytes
        e0 = n_err;
        for (int i = 0; i < 5; i++) send(8'(8'h50 + i), i == 0);
        send(8'hAA, 1'b1);
        for (int i = 0; i < 7; i++) send(8'(8'hB0 + i), 1'b0);
        chk("t4_valid", 32'(op_valid), 32'd1);
        chk("t4_lane0", 32'(op_a[7:0]), 32'hAA);
        chk("t4_one_err", 32'(n_err - e0), 32'd1);
        gap(1);
        // 5: non-SOF bytes while idle are dropped
        e0 = n_err; v0 = n_vrise;
        send(8'h11, 1'b0); send(8'h22, 1'b0);
        gap(5);
        chk("t5_no_err", 32'(n_err - e0), 32'd0);
        chk("t5_no_valid", 32'(n_vrise - v0), 32'd0);
        // 6: async reset mid-LOAD_B and in PRESENT
        for (int i = 0; i < 6; i++) send(8'(8'h11 * (i + 1)), i == 0);
        chk("t6_partial_a", op_a, 32'h44332211);
        #2 rst = 1'b0;
        #1 chk("t6_loadb_a", op_a, 32'd0);
        chk("t6_loadb_b", op_b, 32'd0);
        chk("t6_loadb_ready", 32'(in_ready), 32'd0);
        gap(1); rst = 1'b1; gap(1);
        op_ready = 1'b0;
        send_frame(32'hCAFEF00D, 32'h0BADBEEF);
        gap(2);
        chk("t6_present", 32'(op_valid), 32'd1);
        #2 rst = 1'b0;
        #1 chk("t6_pres_valid", 32'(op_valid), 32'd0);
        chk("t6_pres_a", op_a, 32'd0);
        chk("t6_pres_b", op_b, 32'd0);
        gap(1); rst = 1'b1; gap(1);
        // random frames: truncations, junk bytes, resyncs and timeouts
        rnd = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int len;
            len = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, 7)) : 2*NB;
            if ($urandom_range(0, 3) == 0) send(8'($urandom), 1'b0);
            for (int i = 0; i < len; i++) begin
                send(8'($urandom), i == 0);
                gap(int'($urandom_range(0, 2)));
            end
            if (len < 2*NB && $urandom_range(0, 1) == 1) gap(TO + 2);
        end
        rnd = 1'b0;
        op_ready = 1'b1;
        gap(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
